// File: rtl/mips_pkg.sv
// mips_pkg: constants and fetch FSM state type shared by the MIPS pipeline stages
package mips_pkg;
    localparam logic [31:0] MIPS_NOP      = 32'h0000_0000;
    localparam logic [31:0] MIPS_RESET_PC = 32'h0000_0000;
    typedef enum logic [1:0] {REQ, WAIT, HOLD, DRAIN} fetch_state_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load, stall-hold and flush-to-bubble
module if_id_reg #(
    parameter logic [31:0] NOP_WORD = mips_pkg::MIPS_NOP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        stall_i,
    input  logic        load_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
);
    logic        valid_q, valid_d, keep, take;
    logic [31:0] instr_q, instr_d, pc_q, pc_d, pc4_q, pc4_d;
    assign keep = !flush_i && stall_i && valid_q;
    assign take = !flush_i && !keep && load_i;
    always_comb begin
        valid_d = take || keep;
        instr_d = take ? instr_i : keep ? instr_q : NOP_WORD;
        pc_d    = take ? pc_i : pc_q;
        pc4_d   = take ? pc_i + 32'd4 : pc4_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= NOP_WORD;
            pc_q    <= '0;
            pc4_q   <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
        end
    end
    assign valid_o    = valid_q;
    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc4_q;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: MIPS IF stage, PC plus single-outstanding variable-latency imem fetch
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = MIPS_RESET_PC,
    parameter logic [31:0] NOP_WORD = MIPS_NOP
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
);
    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d, hold_q, hold_d, load_word;
    logic         hs, slot_free, got, load;
    assign imem_req  = rst_n && state_q == REQ;
    assign imem_addr = pc_q;
    assign hs        = imem_req && imem_ready;
    assign slot_free = !if_valid || !id_stall;
    assign got       = state_q == WAIT && imem_rvalid;
    // a redirect kills whatever this cycle would have delivered
    assign load      = !redirect_valid && slot_free && (got || state_q == HOLD);
    assign load_word = state_q == HOLD ? hold_q : imem_rdata;
    always_comb begin
        pc_d    = redirect_valid ? (redirect_pc & 32'hFFFF_FFFC) : load ? pc_q + 32'd4 : pc_q;
        hold_d  = got ? imem_rdata : hold_q;
        state_d = state_q;
        if (redirect_valid) begin
            case (state_q)
                REQ:     state_d = hs ? DRAIN : REQ;
                HOLD:    state_d = REQ;
                default: state_d = imem_rvalid ? REQ : DRAIN;
            endcase
        end else begin
            case (state_q)
                REQ:     state_d = hs ? WAIT : REQ;
                WAIT:    state_d = !imem_rvalid ? WAIT : slot_free ? REQ : HOLD;
                HOLD:    state_d = slot_free ? REQ : HOLD;
                default: state_d = imem_rvalid ? REQ : DRAIN;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
        end
    end
    if_id_reg #(.NOP_WORD(NOP_WORD)) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (redirect_valid),
        .stall_i    (id_stall),
        .load_i     (load),
        .instr_i    (load_word),
        .pc_i       (pc_q),
        .valid_o    (if_valid),
        .instr_o    (if_instruction),
        .pc_o       (if_pc),
        .pc_plus4_o (if_pc_plus4)
    );
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch stage of the MIPS five-stage pipeline. Holds the program counter and issues single-outstanding requests to instruction memory, which may have variable latency. Delivers each fetched word together with its PC into the IF/ID pipeline register consumed by the decode stage. Honours decode stalls and branch/jump redirects, and discards any in-flight fetch made stale by a redirect.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_WORD, 32'h0000_0000, instruction word placed in IF/ID on bubble/flush (sll $0,$0,0)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address, word aligned
- imem_ready  in  1  memory accepts request this cycle (imem_req && imem_ready = handshake)
- imem_rvalid  in  1  read data valid, exactly one per accepted request, earliest the cycle after acceptance
- imem_rdata  in  32  instruction word
- id_stall  in  1  decode cannot consume IF/ID this cycle
- redirect_valid  in  1  branch/jump taken; one-cycle pulse
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0)
- if_valid  out  1  IF/ID holds a real instruction
- if_instruction  out  32  IF/ID instruction
- if_pc  out  32  PC of if_instruction
- if_pc_plus4  out  32  if_pc + 4, modulo 2^32

## Operation
- fetch_pc register; imem_addr = fetch_pc always.
- State machine, states REQ, WAIT, HOLD, DRAIN:
  - REQ: imem_req=1. On handshake -> WAIT. imem_rvalid ignored here.
  - WAIT: await imem_rvalid. If slot free (!if_valid || !id_stall), load IF/ID with {1, imem_rdata, fetch_pc, fetch_pc+4}, fetch_pc += 4, -> REQ. Otherwise capture the word in the hold buffer -> HOLD.
  - HOLD: when slot free, move buffer into IF/ID, fetch_pc += 4, -> REQ.
  - DRAIN: await imem_rvalid, drop the data, -> REQ. No new request is issued.
- IF/ID update when not redirecting: if id_stall && if_valid, hold all fields; otherwise load new instruction if one is available this cycle, else load bubble (if_valid=0, if_instruction=NOP_WORD; if_pc/if_pc_plus4 hold).
- Redirect (highest priority, overrides id_stall): fetch_pc <= {redirect_pc[31:2],2'b00}; IF/ID flushed to bubble; hold buffer discarded. Next state:
  - REQ without handshake: REQ.
  - REQ with handshake: DRAIN.
  - WAIT without rvalid: DRAIN.
  - WAIT with rvalid: REQ (data dropped).
  - HOLD: REQ.
  - DRAIN: DRAIN, or REQ if rvalid this cycle.
- Arithmetic: +4 wraps 32'hFFFF_FFFC -> 32'h0000_0000; no exception raised.

## Timing
- Reset (async assert): state REQ, fetch_pc=RESET_PC, imem_req=0 while rst_n low, if_valid=0, if_instruction=NOP_WORD, if_pc=0, if_pc_plus4=0, hold buffer empty.
- First cycle after rst_n rises: imem_req=1, imem_addr=RESET_PC.
- Latency: handshake in cycle N, rvalid in N+1 -> if_valid=1 from N+2.
- Peak throughput: one instruction per 2 cycles, with a single request outstanding.
- Redirect in cycle N: IF/ID is a bubble at N+1. A request to the target is issued at N+1, or after the drain completes.
- Reset mid-fetch aborts everything; a stale rvalid arriving in REQ is ignored.

## Structure
- Shared package mips_pkg: NOP_WORD, default RESET_PC, typedef fetch_state_t {REQ, WAIT, HOLD, DRAIN}.
- One sub-module, if_id_reg: the IF/ID register with load/hold/flush controls and async reset. The FSM and PC remain in instruction_fetch.

## Test plan
- Reset, memory 1-cycle latency, rdata = addr ^ 32'hA5A5_0000 -> if_pc sequence 0,4,8,12 with matching words; if_valid every other cycle.
- id_stall high for 5 cycles while a response arrives -> IF/ID held, word parked in HOLD, no imem_req; after release, the word appears once with no PC skipped.
- redirect_pc=32'h0000_0101 in WAIT with rvalid 3 cycles later -> DRAIN, stale word never reaches IF/ID, next imem_addr=32'h0000_0100.
- Redirect and id_stall in the same cycle, if_valid=1 -> IF/ID flushed to NOP_WORD with if_valid=0.
- fetch_pc=32'hFFFF_FFFC fetched -> if_pc_plus4=0, next imem_addr=0.
- rst_n pulsed low mid-WAIT, late rvalid in REQ -> ignored; fetch restarts at RESET_PC.
